// File: rtl/sparce_skip_unit.sv
// -----------------------------------------------------------------------------
// sparce_skip_unit
//
// Sparsity-aware skip unit for an RV32I fetch stage. A 32-bit zero-flag
// register file (SVRF) is kept up to date from writeback. Software programs a
// table of skippable regions (SASA). When the fetch PC matches an armed entry
// whose operand registers satisfy the entry's zero condition, fetch is
// redirected past the region.
//
// Parameters
//   SASA_ENTRIES : table depth (power of 2, 2..32)
//   SKIP_W       : skip distance width, in instructions (1..12)
//   COUNT_W      : width of the saturating consumed-skip counter
//   SASA_BASE    : 4 KiB-aligned base of the configuration store window
//
// Ports
//   CLK, RST      : clock, asynchronous active-high reset
//   pc            : current fetch PC
//   if_ex_enable  : fetch stage advances this cycle
//   flush         : pipeline flush, discards a pending skip
//   wb_en/rd/wb_data          : register writeback
//   sasa_wen/sasa_addr/sasa_data : configuration stores
//   skipping      : redirect fetch to sparce_target
//   sparce_target : redirect PC
//   skip_count    : number of consumed skips, saturating
// -----------------------------------------------------------------------------
module sparce_skip_unit #(
  parameter int          SASA_ENTRIES = 8,
  parameter int          SKIP_W       = 5,
  parameter int          COUNT_W      = 16,
  parameter logic [31:0] SASA_BASE    = 32'hFFFF_F000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        pc,
  input  logic               if_ex_enable,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [4:0]         rd,
  input  logic [31:0]        wb_data,
  input  logic               sasa_wen,
  input  logic [31:0]        sasa_addr,
  input  logic [31:0]        sasa_data,
  output logic               skipping,
  output logic [31:0]        sparce_target,
  output logic [COUNT_W-1:0] skip_count
);

  localparam int IDX_W  = $clog2(SASA_ENTRIES);
  localparam int CTRL_W = SKIP_W + 12;
  // ctrl without its valid bit; valid lives in its own resettable vector
  localparam int BODY_W = SKIP_W + 11;

  // ---------------------------------------------------------------------------
  // SVRF: zero flags per architectural register
  // ---------------------------------------------------------------------------
  logic [31:0] flag_q;
  logic [31:0] flag_d;

  // flag_d is also the bypassed view used by the lookup: a writeback in this
  // cycle is already reflected in it, and x0 always reads as zero.
  always_comb begin
    flag_d = flag_q;
    if (wb_en && (rd != 5'd0)) begin
      flag_d[rd] = (wb_data == 32'd0);
    end
    flag_d[0] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flag_q <= '1;
    end else begin
      flag_q <= flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SASA table
  // ---------------------------------------------------------------------------
  logic [29:0]             tag_q  [SASA_ENTRIES];
  logic [BODY_W-1:0]       body_q [SASA_ENTRIES];
  logic [SASA_ENTRIES-1:0] valid_q;
  logic [SASA_ENTRIES-1:0] valid_d;

  logic             cfg_hit;
  logic [IDX_W-1:0] cfg_idx;

  assign cfg_hit = sasa_wen && (sasa_addr[31:12] == SASA_BASE[31:12]);
  assign cfg_idx = sasa_addr[3 +: IDX_W];

  // Tags and ctrl bodies carry no reset; an entry is only trusted once valid.
  always_ff @(posedge CLK) begin
    if (cfg_hit) begin
      if (sasa_addr[2]) begin
        body_q[cfg_idx] <= sasa_data[BODY_W-1:0];
      end else begin
        tag_q[cfg_idx] <= sasa_data[31:2];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (cfg_hit && sasa_addr[2]) begin
      valid_d[cfg_idx] = sasa_data[CTRL_W-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry match
  // ---------------------------------------------------------------------------
  logic [SASA_ENTRIES-1:0] hit;
  logic [SKIP_W-1:0]       ent_skip [SASA_ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < SASA_ENTRIES; gi++) begin : g_ent
      logic [SKIP_W-1:0] skip_f;
      logic [4:0]        rs1_f;
      logic [4:0]        rs2_f;
      logic              mode_f;
      logic              cond;

      assign skip_f = body_q[gi][SKIP_W-1:0];
      assign rs1_f  = body_q[gi][SKIP_W+4:SKIP_W];
      assign rs2_f  = body_q[gi][SKIP_W+9:SKIP_W+5];
      assign mode_f = body_q[gi][SKIP_W+10];

      // mode 1 = OR, mode 0 = AND
      assign cond = mode_f ? (flag_d[rs1_f] | flag_d[rs2_f])
                           : (flag_d[rs1_f] & flag_d[rs2_f]);

      assign hit[gi]      = valid_q[gi] && (skip_f != '0) &&
                            (tag_q[gi] == pc[31:2]) && cond;
      assign ent_skip[gi] = skip_f;
    end
  endgenerate

  // Lowest-index hit wins: scan downward so the last assignment is the lowest.
  logic              win;
  logic [SKIP_W-1:0] win_skip;

  always_comb begin
    win      = 1'b0;
    win_skip = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win      = 1'b1;
        win_skip = ent_skip[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending skip, target and statistics
  // ---------------------------------------------------------------------------
  logic               pending_q;
  logic               pending_d;
  logic [31:0]        target_q;
  logic [31:0]        target_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    count_d   = count_q;
    if (flush) begin
      // flush wins over both consume and load; a flushed skip is not counted
      pending_d = 1'b0;
    end else if (pending_q) begin
      if (if_ex_enable) begin
        pending_d = 1'b0;
        if (count_q != '1) begin
          count_d = count_q + COUNT_W'(1);
        end
      end
    end else if (if_ex_enable && win) begin
      pending_d = 1'b1;
      // skip is in instructions; wraps modulo 2^32
      target_d  = pc + {{(30 - SKIP_W){1'b0}}, win_skip, 2'b00};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= 1'b0;
      target_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      count_q   <= count_d;
    end
  end

  assign skipping      = pending_q;
  assign sparce_target = target_q;
  assign skip_count    = count_q;

  // Address bits that play no part in decode
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], sasa_addr[1:0], sasa_addr[11:3+IDX_W]};

endmodule

// File: doc/sparce_skip_unit.md
# sparce_skip_unit

Parametrised sparsity-aware skip unit (SparCE) for the RV32I pipeline. It tracks a per-register zero flag (the SVRF) from writeback and holds a software-programmed SASA table of skippable code regions. On a fetch PC that matches an armed entry whose source operands are zero, it redirects fetch past the region. This generalises the fixed single-table SparCE unit with:

- configurable table depth and skip range;
- AND/OR operand conditions;
- a held skip handshake under stall, plus flush;
- a skip statistics counter.

## Interface
Parameters:
- SASA_ENTRIES, 8, table entries (power of 2, 2..32)
- SKIP_W, 5, skip distance width in instructions (1..12)
- COUNT_W, 16, skip counter width
- SASA_BASE, 32'hFFFF_F000, 4 KiB-aligned config window base

Ports:
- CLK  in  1  pipeline clock
- RST  in  1  asynchronous, active-high reset
- pc  in  32  current fetch PC
- if_ex_enable  in  1  fetch stage advancing this cycle
- flush  in  1  pipeline flush; discards pending skip
- wb_en  in  1  register writeback valid
- rd  in  5  writeback destination
- wb_data  in  32  writeback value
- sasa_wen  in  1  config store valid
- sasa_addr  in  32  config store address
- sasa_data  in  32  config store data
- skipping  out  1  redirect fetch to sparce_target
- sparce_target  out  32  redirect PC
- skip_count  out  COUNT_W  consumed skips, saturating

## Operation
- SVRF: 32 flag bits.
  - On wb_en with rd!=0, set flag[rd] <= (wb_data==0).
  - flag[0] is constantly 1.
  - Reset sets all flags to 1.
- SASA entry fields:
  - tag[29:0] (PC[31:2])
  - ctrl: skip[SKIP_W-1:0], rs1[SKIP_W+4:SKIP_W], rs2[SKIP_W+9:SKIP_W+5], mode[SKIP_W+10] (0=AND, 1=OR), valid[SKIP_W+11]
- Config writes:
  - A write is accepted when sasa_wen and sasa_addr[31:12]==SASA_BASE[31:12].
  - Entry index = sasa_addr[3 +: log2(SASA_ENTRIES)].
  - sasa_addr[2]=0 writes the tag from sasa_data[31:2].
  - sasa_addr[2]=1 writes ctrl from the low SKIP_W+12 bits.
  - Writes outside the window are ignored.
  - Reset clears all valid bits. Tags and ctrl fields are not reset.
- Lookup (combinational, each cycle with if_ex_enable=1, no pending skip, flush=0):
  - Entry i hits when valid && skip!=0 && tag==pc[31:2].
  - Operand zero test uses the SVRF with a same-cycle writeback bypass: if wb_en && rd==rsN && rd!=0, use (wb_data==0).
  - Condition: AND requires z(rs1)&z(rs2). OR requires z(rs1)|z(rs2). For single-operand use, set rs2=rs1.
  - The lowest-index hit with a true condition wins.
  - target = pc + {skip,2'b00}, 32-bit modular (wraps).
- Pending skip register:
  - Loads on a winning lookup.
  - Drives skipping=1 and sparce_target until consumed: the first cycle with if_ex_enable=1 after load clears it.
  - No new lookup occurs while pending.
- flush clears pending in the same edge and blocks a lookup that cycle. flush has priority over load and consume.
- skip_count increments on consume. It saturates at all-ones. Flushed skips are not counted.

## Timing
- Reset values: skipping=0, sparce_target=0, skip_count=0, all valid=0, SVRF=all 1.
- Latency: lookup on pc in cycle N (if_ex_enable=1) gives skipping=1 from cycle N+1.
- skipping holds through if_ex_enable=0 cycles. It falls after the first edge with if_ex_enable=1.
- A config write in cycle N affects lookups from N+1. A lookup in N sees old table contents.
- A writeback in cycle N is visible to a lookup in N via the bypass.
- Asynchronous RST mid-pending drops skipping immediately and keeps it 0 until RST releases.

## Test plan
- Program entry 0: tag=0x100, skip=4, rs1=rs2=5, AND, valid. Write x5=0. Present pc=0x100 with if_ex_enable=1 -> next cycle skipping=1, sparce_target=0x110. Next if_ex_enable cycle -> skipping=0, skip_count=1.
- Same entry with x5=7 written in the lookup cycle -> no skip. Write x5=0 and present pc=0x100 in the same cycle -> skip (bypass).
- OR mode, rs1=3 (x3=0), rs2=4 (x4=9) -> skip. Switch to AND -> no skip. rd=0 writeback of 9 -> x0 still zero.
- Entries 2 and 5 both tag 0x200 with skip=1 and skip=3, both conditions true -> target 0x204 (entry 2 wins).
- Pending skip with if_ex_enable=0 for 3 cycles -> skipping held and target stable. Assert flush -> skipping=0, skip_count unchanged.
- tag=0xFFFFFFFC, skip=2 -> target 0x00000004. COUNT_W=2 with 5 consumed skips -> skip_count=3. Write to sasa_addr=0x0000_1004 -> table unchanged.
